sram_controller: RTL and testbench
==================================

# sram_controller

Parametrised successor to the single-byte external SRAM port. It turns one core-side word access of `BUS_DW` bits with byte enables into a sequence of byte-wide accesses on an asynchronous 8-bit SRAM. Each byte access is a timed SETUP/STROBE/HOLD cycle with a configurable strobe width. The block sits between the core's data-memory port and the external SRAM pins.

## Interface
- `ADDR_W`, 32: address width, core side and pin side.
- `BUS_DW`, 32: core data width; a multiple of 8 in the range 8..64. Number of lanes `LANES = BUS_DW/8`, lane index width `LB = log2(LANES)`.
- `WAIT_CYCLES`, 1: strobe width in clocks, must be ≥1.
- `MODEL_DEPTH`, 1024: byte depth of the behavioural SRAM model (used only under the macro).
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `req_i`  in  1  access request; accepted on an edge where the FSM is in IDLE.
- `we_i`  in  1  1 = write, 0 = read; sampled at acceptance.
- `be_i`  in  LANES  byte enables; sampled at acceptance.
- `addr_i`  in  ADDR_W  byte address; the low `LB` bits are ignored (word-aligned).
- `wdata_i`  in  BUS_DW  write data; sampled at acceptance.
- `rdata_o`  out  BUS_DW  read data; valid while `ack_o` = 1.
- `ack_o`  out  1  one-cycle completion pulse.
- `stall_o`  out  1  high while an access is in flight.
- `ce_no`, `we_no`, `oe_no`  out  1 each  SRAM strobes, active-low.
- `addr_o`  out  ADDR_W  SRAM byte address.
- `data_io`  inout  8  SRAM data pins; high-Z unless the block is writing.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE. All outputs are registered and decoded from the current state.
- **IDLE:**
  - If `req_i` = 1, latch `we_i`, `be_i`, `addr_i` and `wdata_i`, and clear `rdata_o` to 0.
  - Set `lane` to the lowest set bit of `be_i`.
  - Go to SETUP, or go straight to DONE if `be_i` = 0.
- **Lane order and mapping:**
  - Lanes are serviced in ascending order; lanes with their `be` bit clear are skipped.
  - Little-endian: lane k maps to `wdata[8k+7:8k]` / `rdata[8k+7:8k]`.
  - `addr_o = {addr[ADDR_W-1:LB], lane}`. When `BUS_DW` = 8, `addr_o = addr`.
- **SETUP (1 cycle):** `ce_no` = 0, `we_no` = 1, `oe_no` = 1. For writes, `data_io` drives the lane byte.
- **STROBE (`WAIT_CYCLES` cycles, counted by a down-counter):**
  - Writes: `we_no` = 0.
  - Reads: `oe_no` = 0. The lane byte of `data_io` is captured into `rdata_o` on the edge that leaves STROBE.
- **HOLD (1 cycle):**
  - `we_no` = 1, `oe_no` = 1, `ce_no` = 0. Address and write data are held.
  - Go to SETUP for the next enabled lane, or to DONE if none remain.
- **DONE (1 cycle):** `ce_no` = 1, `ack_o` = 1, `rdata_o` valid (disabled lanes read 0). Next state is IDLE.
- **Data drive:** `data_io` is driven only for writes, in SETUP, STROBE and HOLD; it is high-Z in every other state.
- **`rdata_o` lifetime:** holds its value after DONE until the next acceptance.
- **Request handshake:** `req_i` is ignored outside IDLE. The core keeps `req_i` high through DONE and deasserts it in the `ack_o` cycle if it does not want a back-to-back access.

## Timing
- **Reset values:** `stall_o` = 0, `ack_o` = 0, `ce_no` = `we_no` = `oe_no` = 1, `addr_o` = 0, `rdata_o` = 0, `data_io` = Z, FSM in IDLE.
- **Reset mid-access:** strobes deassert asynchronously and the FSM returns to IDLE. A partially written word is left as written; no recovery is attempted.
- **Per-lane cost:** `2 + WAIT_CYCLES` clocks.
- **Latency:** with N enabled lanes, `ack_o` is high in cycle `N*(2+WAIT_CYCLES)+1` after the acceptance edge. With N = 0, `ack_o` is high in cycle 1.
- **`stall_o`:** high in every state except IDLE, including DONE.
- **Write strobe:** `we_no` rises at the start of HOLD, so address and data are stable one full cycle on both sides of the strobe.
- **Back-to-back:** from DONE the FSM goes to IDLE, so there is a minimum of one idle cycle between accesses.

## Configuration
- `SRAM_MODEL_EN` defined:
  - Instantiates a behavioural asynchronous SRAM of `MODEL_DEPTH` bytes on the pins.
  - Writes on the rising edge of `we_no` while `ce_no` = 0.
  - Drives `data_io` while `ce_no` = 0 and `oe_no` = 0.
  - Address is taken modulo `MODEL_DEPTH`.
- `SRAM_MODEL_EN` not defined: no model is instantiated; the pins connect only to the top level. The port list is identical either way.

## Test plan
Unless stated otherwise: `SRAM_MODEL_EN` defined, `BUS_DW` = 32, `WAIT_CYCLES` = 1.
- **Reset:** hold `rst_ni` = 0 → all outputs at their reset values; `data_io` = Z.
- **Full write:** `addr` 0x10, `wdata` 0xDEADBEEF, `be` 0xF → model[0x10..0x13] = EF BE AD DE; exactly four one-cycle `we_no` pulses; `ack_o` in cycle 13.
- **Full read:** `addr` 0x12 (low bits ignored), `be` 0xF → `rdata_o` = 0xDEADBEEF in cycle 13; `data_io` never driven by the controller.
- **Partial write and readback:** write `be` 0x4, `wdata` 0x00550000 to 0x10 → one strobe at `addr_o` 0x12 and `ack_o` in cycle 4. A following full read returns 0xDE55BEEF.
- **Empty access and back-to-back:** `be` 0 → `ack_o` in cycle 1 with no `ce_no` activity. Keeping `req_i` high through DONE starts the next access after one idle cycle.
- **Longer strobe and reset mid-access:** `WAIT_CYCLES` = 3 → `oe_no` low for 3 cycles per lane; a full read acks in cycle 21. Asserting `rst_ni` during the lane-1 STROBE → strobes high immediately, `stall_o` = 0.

Source files
------------

// File: rtl/sram_controller.sv
// sram_controller: serialises one BUS_DW-bit core access into timed byte cycles on an async 8-bit SRAM.
// Define SRAM_MODEL_EN to attach a behavioural SRAM model of MODEL_DEPTH bytes to the pins.

`ifdef SRAM_MODEL_EN
module sram_controller_model #(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 1024
) (
   input  logic              ce_ni,
   input  logic              we_ni,
   input  logic              oe_ni,
   input  logic [ADDR_W-1:0] addr_i,
   inout  wire  [7:0]        data_io
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [7:0]    mem [DEPTH];
   logic [IW-1:0] idx;

   assign idx = IW'(addr_i % ADDR_W'(DEPTH));

   // Asynchronous SRAM: data is latched on the trailing edge of the write strobe.
   always_ff @(posedge we_ni) begin
      if (!ce_ni) mem[idx] <= data_io;
   end

   assign data_io = (!ce_ni && !oe_ni) ? mem[idx] : 8'hzz;
endmodule
`endif

module sram_controller #(
   parameter int ADDR_W      = 32,
   parameter int BUS_DW      = 32,
   parameter int WAIT_CYCLES = 1,
   parameter int MODEL_DEPTH = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [BUS_DW/8-1:0]   be_i,
   input  logic [ADDR_W-1:0]     addr_i,
   input  logic [BUS_DW-1:0]     wdata_i,
   output logic [BUS_DW-1:0]     rdata_o,
   output logic                  ack_o,
   output logic                  stall_o,
   output logic                  ce_no,
   output logic                  we_no,
   output logic                  oe_no,
   output logic [ADDR_W-1:0]     addr_o,
   inout  wire  [7:0]            data_io
);
   localparam int LANES = BUS_DW / 8;
   localparam int LB    = (LANES > 1) ? $clog2(LANES) : 0;
   localparam int LW    = (LB > 0) ? LB : 1;
   localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETUP  = 3'd1;
   localparam logic [2:0] S_STROBE = 3'd2;
   localparam logic [2:0] S_HOLD   = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]           state_q, state_d;
   logic                 wr_q, wr_d;
   logic [LANES-1:0]     pend_q, pend_d;
   logic [ADDR_W-LB-1:0] word_q, word_d, word_in;
   logic [BUS_DW-1:0]    wdata_q, wdata_d;
   logic [BUS_DW-1:0]    rdata_q, rdata_d;
   logic [LW-1:0]        lane_q, lane_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 ce_n_q, ce_n_d;
   logic                 we_n_q, we_n_d;
   logic                 oe_n_q, oe_n_d;
   logic                 ack_q, ack_d;
   logic                 stall_q, stall_d;
   logic                 drive_q, drive_d;
   logic [7:0]           dout_q, dout_d;
   logic [ADDR_W-1:0]    addr_o_q, addr_o_d;
   logic                 active;

   function automatic logic [LW-1:0] lowest_lane(input logic [LANES-1:0] m);
      lowest_lane = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (m[i]) lowest_lane = LW'(i);
      end
   endfunction

   generate
      if (LB == 0) begin : g_byte_bus
         assign word_in  = addr_i;
         assign addr_o_d = word_d;
      end else begin : g_word_bus
         // Byte offset inside the word comes from the lane, never from the core address.
         logic unused_low_addr;
         assign unused_low_addr = ^addr_i[LB-1:0];
         assign word_in         = addr_i[ADDR_W-1:LB];
         assign addr_o_d        = {word_d, lane_d[LB-1:0]};
      end
   endgenerate

   assign dout_d = wdata_d[lane_d*8 +: 8];

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      pend_d  = pend_q;
      word_d  = word_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      lane_d  = lane_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               wr_d    = we_i;
               pend_d  = be_i;
               word_d  = word_in;
               wdata_d = wdata_i;
               rdata_d = '0;
               lane_d  = lowest_lane(be_i);
               state_d = (be_i == '0) ? S_DONE : S_SETUP;
            end
         end
         S_SETUP: begin
            cnt_d   = CW'(WAIT_CYCLES - 1);
            state_d = S_STROBE;
         end
         S_STROBE: begin
            if (cnt_q == '0) begin
               state_d = S_HOLD;
               if (!wr_q) rdata_d[lane_q*8 +: 8] = data_io;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_HOLD: begin
            pend_d = pend_q & ~(LANES'(1) << lane_q);
            if (pend_d == '0) begin
               state_d = S_DONE;
            end else begin
               lane_d  = lowest_lane(pend_d);
               state_d = S_SETUP;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Pin outputs are registered copies of the decode of the next state.
      active  = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
      ce_n_d  = !active;
      we_n_d  = !((state_d == S_STROBE) && wr_d);
      oe_n_d  = !((state_d == S_STROBE) && !wr_d);
      ack_d   = (state_d == S_DONE);
      stall_d = (state_d != S_IDLE);
      drive_d = active && wr_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         wr_q     <= 1'b0;
         pend_q   <= '0;
         word_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         lane_q   <= '0;
         cnt_q    <= '0;
         ce_n_q   <= 1'b1;
         we_n_q   <= 1'b1;
         oe_n_q   <= 1'b1;
         ack_q    <= 1'b0;
         stall_q  <= 1'b0;
         drive_q  <= 1'b0;
         dout_q   <= '0;
         addr_o_q <= '0;
      end else begin
         state_q  <= state_d;
         wr_q     <= wr_d;
         pend_q   <= pend_d;
         word_q   <= word_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         lane_q   <= lane_d;
         cnt_q    <= cnt_d;
         ce_n_q   <= ce_n_d;
         we_n_q   <= we_n_d;
         oe_n_q   <= oe_n_d;
         ack_q    <= ack_d;
         stall_q  <= stall_d;
         drive_q  <= drive_d;
         dout_q   <= dout_d;
         addr_o_q <= addr_o_d;
      end
   end

   assign rdata_o = rdata_q;
   assign ack_o   = ack_q;
   assign stall_o = stall_q;
   assign ce_no   = ce_n_q;
   assign we_no   = we_n_q;
   assign oe_no   = oe_n_q;
   assign addr_o  = addr_o_q;
   assign data_io = drive_q ? dout_q : 8'hzz;

`ifdef SRAM_MODEL_EN
   sram_controller_model #(
      .ADDR_W (ADDR_W),
      .DEPTH  (MODEL_DEPTH)
   ) u_model (
      .ce_ni   (ce_n_q),
      .we_ni   (we_n_q),
      .oe_ni   (oe_n_q),
      .addr_i  (addr_o_q),
      .data_io (data_io)
   );
`else
   localparam int unused_model_depth = MODEL_DEPTH;
`endif
endmodule

// File: tb/tb_sram_controller.sv
// Testbench for sram_controller: table of accesses checked through a scoreboard, plus
// hand-written back-to-back and reset-mid-access sequences on a WAIT_CYCLES=3 instance.
module tb_sram_controller;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1_n, rst3_n, req, we, sel;
   logic [3:0]  be;
   logic [31:0] addr, wdata;
   wire         req1 = req & ~sel;
   wire         req3 = req & sel;

   logic [31:0] rdata1, rdata3, addr1, addr3;
   logic        ack1, ack3, stall1, stall3;
   logic        ce1_n, ce3_n, we1_n, we3_n, oe1_n, oe3_n;
   wire  [7:0]  data1, data3;

   pulldown (data1);
   pulldown (data3);

   sram_controller #(.ADDR_W(32), .BUS_DW(32), .WAIT_CYCLES(1), .MODEL_DEPTH(1024)) dut1 (
      .clk_i(clk), .rst_ni(rst1_n), .req_i(req1), .we_i(we), .be_i(be), .addr_i(addr),
      .wdata_i(wdata), .rdata_o(rdata1), .ack_o(ack1), .stall_o(stall1), .ce_no(ce1_n),
      .we_no(we1_n), .oe_no(oe1_n), .addr_o(addr1), .data_io(data1));

   sram_controller #(.ADDR_W(32), .BUS_DW(32), .WAIT_CYCLES(3), .MODEL_DEPTH(1024)) dut3 (
      .clk_i(clk), .rst_ni(rst3_n), .req_i(req3), .we_i(we), .be_i(be), .addr_i(addr),
      .wdata_i(wdata), .rdata_o(rdata3), .ack_o(ack3), .stall_o(stall3), .ce_no(ce3_n),
      .we_no(we3_n), .oe_no(oe3_n), .addr_o(addr3), .data_io(data3));

   // Bench-side view of the SRAM: records every byte strobed in on the pins.
   logic [7:0] tb_mem1 [256];
   logic [7:0] tb_mem3 [256];
   always @(posedge we1_n) if (!ce1_n) tb_mem1[addr1[7:0]] <= data1;
   always @(posedge we3_n) if (!ce3_n) tb_mem3[addr3[7:0]] <= data3;
`ifndef SRAM_MODEL_EN
   assign data1 = (!ce1_n && !oe1_n) ? tb_mem1[addr1[7:0]] : 8'hzz;
   assign data3 = (!ce3_n && !oe3_n) ? tb_mem3[addr3[7:0]] : 8'hzz;
`endif

   wire [31:0] m_rdata = sel ? rdata3 : rdata1;
   wire [31:0] m_addr  = sel ? addr3  : addr1;
   wire        m_ack   = sel ? ack3   : ack1;
   wire        m_stall = sel ? stall3 : stall1;
   wire        m_ce_n  = sel ? ce3_n  : ce1_n;
   wire        m_we_n  = sel ? we3_n  : we1_n;
   wire        m_oe_n  = sel ? oe3_n  : oe1_n;
   wire [7:0]  m_data  = sel ? data3  : data1;

   typedef struct {
      logic        sel;
      logic        wr;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_cycle;
      int          exp_falls;
      int          exp_low;
      logic [31:0] exp_first;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      int          cycle;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[10];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int          cyc, we_falls, oe_falls, low_cnt, ce_low, stall_cnt, float_bad;
      logic        prev_we, prev_oe, done;
      logic [31:0] first_addr;
      exp_t        e;
      @(negedge clk);
      sel = v.sel; we = v.wr; be = v.be; addr = v.addr; wdata = v.wdata; req = 1'b1;
      sb_q.push_back('{v.exp_rdata, v.exp_cycle});
      cyc = 0; we_falls = 0; oe_falls = 0; low_cnt = 0; ce_low = 0; stall_cnt = 0;
      float_bad = 0; prev_we = 1'b1; prev_oe = 1'b1; done = 1'b0; first_addr = 32'hFFFF_FFFF;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (m_stall) stall_cnt++;
         if (!m_ce_n) ce_low++;
         if (!m_ce_n && first_addr == 32'hFFFF_FFFF) first_addr = m_addr;
         if (!m_we_n || !m_oe_n) low_cnt++;
         if (prev_we && !m_we_n) we_falls++;
         if (prev_oe && !m_oe_n) oe_falls++;
         if (!v.wr && !m_ce_n && m_oe_n && m_data !== 8'h00) float_bad++;
         prev_we = m_we_n;
         prev_oe = m_oe_n;
         if (m_ack) begin
            done = 1'b1;
            req  = 1'b0;
         end
      end
      check($sformatf("v%0d_ack_seen", idx), {31'd0, done}, 32'd1);
      if (done) begin
         e = sb_q.pop_front();
         check($sformatf("v%0d_rdata", idx), m_rdata, e.rdata);
         check($sformatf("v%0d_ack_cycle", idx), cyc, e.cycle);
      end else begin
         req = 1'b0;
         void'(sb_q.pop_front());
      end
      check($sformatf("v%0d_strobes", idx), v.wr ? we_falls : oe_falls, v.exp_falls);
      check($sformatf("v%0d_other_strobe", idx), v.wr ? oe_falls : we_falls, 0);
      check($sformatf("v%0d_strobe_low", idx), low_cnt, v.exp_low);
      check($sformatf("v%0d_ce_low", idx), ce_low, v.exp_cycle - 1);
      check($sformatf("v%0d_stall", idx), stall_cnt, v.exp_cycle);
      check($sformatf("v%0d_first_addr", idx), first_addr, v.exp_first);
      check($sformatf("v%0d_data_float", idx), float_bad, 0);
      $display("txn %0d dut_w%0d %s be=%h addr=%h rdata=%h ack_cycle=%0d", idx,
               v.sel ? 3 : 1, v.wr ? "WR" : "RD", v.be, v.addr, m_rdata, cyc);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cyc;
      logic got;
      exp_t e;

      vecs[0] = '{1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0,        13, 4, 4,  32'h10};
      vecs[1] = '{1'b0, 1'b0, 4'hF, 32'h12, 32'hFFFFFFFF, 32'hDEADBEEF, 13, 4, 4,  32'h10};
      vecs[2] = '{1'b0, 1'b1, 4'h4, 32'h10, 32'h00550000, 32'h0,        4,  1, 1,  32'h12};
      vecs[3] = '{1'b0, 1'b0, 4'hF, 32'h10, 32'hFFFFFFFF, 32'hDE55BEEF, 13, 4, 4,  32'h10};
      vecs[4] = '{1'b0, 1'b0, 4'h5, 32'h13, 32'hFFFFFFFF, 32'h005500EF, 7,  2, 2,  32'h10};
      vecs[5] = '{1'b0, 1'b1, 4'hA, 32'h20, 32'h11223344, 32'h0,        7,  2, 2,  32'h21};
      vecs[6] = '{1'b0, 1'b0, 4'hA, 32'h22, 32'hFFFFFFFF, 32'h11003300, 7,  2, 2,  32'h21};
      vecs[7] = '{1'b0, 1'b0, 4'h0, 32'h40, 32'hFFFFFFFF, 32'h0,        1,  0, 0,  32'hFFFFFFFF};
      vecs[8] = '{1'b1, 1'b1, 4'hF, 32'h00, 32'h89ABCDEF, 32'h0,        21, 4, 12, 32'h0};
      vecs[9] = '{1'b1, 1'b0, 4'hF, 32'h01, 32'hFFFFFFFF, 32'h89ABCDEF, 21, 4, 12, 32'h0};

      rst1_n = 1'b0; rst3_n = 1'b0; req = 1'b0; we = 1'b0; sel = 1'b0;
      be = 4'h0; addr = 32'h0; wdata = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_stall", {stall1, stall3}, 2'b00);
      check("rst_ack", {ack1, ack3}, 2'b00);
      check("rst_strobes", {ce1_n, we1_n, oe1_n, ce3_n, we3_n, oe3_n}, 6'b111111);
      check("rst_addr", addr1 | addr3, 32'h0);
      check("rst_rdata", rdata1 | rdata3, 32'h0);
      check("rst_data_z", {data1, data3}, 16'h0000);
      rst1_n = 1'b1; rst3_n = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

      check("mem_10", tb_mem1[8'h10], 8'hEF);
      check("mem_11", tb_mem1[8'h11], 8'hBE);
      check("mem_12", tb_mem1[8'h12], 8'h55);
      check("mem_13", tb_mem1[8'h13], 8'hDE);
      check("mem_21", tb_mem1[8'h21], 8'h33);
      check("mem_23", tb_mem1[8'h23], 8'h11);
      check("mem3_02", tb_mem3[8'h02], 8'hAB);

      // Back-to-back: req held through DONE of an empty access, then a one-lane read.
      @(negedge clk);
      sel = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h10; wdata = 32'hFFFF_FFFF; req = 1'b1;
      @(negedge clk);
      check("b2b_first_ack", ack1, 1'b1);
      check("b2b_first_ce", ce1_n, 1'b1);
      be = 4'h1;
      @(negedge clk);
      check("b2b_gap_ack", ack1, 1'b0);
      check("b2b_gap_stall", stall1, 1'b0);
      sb_q.push_back('{32'h0000_00EF, 4});
      cyc = 0; got = 1'b0;
      while (!got && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) check("b2b_setup_ce", ce1_n, 1'b0);
         if (ack1) got = 1'b1;
      end
      req = 1'b0;
      check("b2b_ack_seen", {31'd0, got}, 32'd1);
      e = sb_q.pop_front();
      check("b2b_rdata", rdata1, e.rdata);
      check("b2b_ack_cycle", cyc, e.cycle);
      $display("txn b2b dut_w1 RD be=1 addr=00000010 rdata=%h ack_cycle=%0d", rdata1, cyc);

      // Reset in the middle of the lane-1 strobe on the WAIT_CYCLES=3 instance.
      @(negedge clk);
      sel = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0; req = 1'b1;
      repeat (8) @(negedge clk);
      check("mid_in_strobe", oe3_n, 1'b0);
      check("mid_lane1_addr", addr3, 32'h1);
      rst3_n = 1'b0;
      req    = 1'b0;
      #1;
      check("mid_rst_strobes", {ce3_n, we3_n, oe3_n}, 3'b111);
      check("mid_rst_stall", stall3, 1'b0);
      check("mid_rst_ack", ack3, 1'b0);
      @(negedge clk);
      rst3_n = 1'b1;
      @(negedge clk);
      check("mid_after_idle", {stall3, ce3_n}, 2'b01);
      $display("txn rst_mid dut_w3 RD be=f addr=00000000 reset during lane 1 strobe");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
